spi_frame_rx: RTL and testbench

Parametrised SPI slave receiver that replaces the free-running 48-bit shift register feeding `top`. It samples `sck`, `sdi` and `CE` in the `clk` domain, frames data on `CE`, and checks each frame's bit count. It queues complete frames in a small FIFO and hands them to the PWM/control logic over a valid/ready handshake, with sticky error and overflow flags.

---
 rtl/spi_rx_pkg.sv | 21 ++
 rtl/spi_frame_fifo.sv | 78 +++++++
 rtl/spi_frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the SPI frame receiver.
package spi_rx_pkg;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Bit counter width for the default 48-bit frame. The counter must reach
  // FRAME_W+1 so that overlong frames saturate instead of wrapping.
  localparam int FRAME_W_DEFAULT = 48;
  localparam int CNT_W = $clog2(FRAME_W_DEFAULT + 2);

  // Same sizing rule for any frame width, usable from parameterised modules.
  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 2);
  endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Small synchronous frame FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter. The head word is
// held in a register that always reflects the post-update head, so it is
// valid in the same cycle the FIFO reports non-empty.
module spi_frame_fifo
  import spi_rx_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  wr_ptr_n;
  logic [AW:0]  rd_ptr_n;
  logic         do_push;
  logic         do_pop;
  logic         empty_n;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees a slot in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};
  assign empty_n  = (wr_ptr_n == rd_ptr_n);

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
    end
  end

  // Registered head read. When the incoming word becomes the new head it is
  // forwarded directly, since the array write lands at the same edge.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      dout <= '0;
    end else if (empty_n) begin
      dout <= '0;
    end else if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
      dout <= din;
    end else begin
      dout <= mem[rd_ptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver (CPOL=0). sck, sdi and CE are resynchronised into
// the clk domain, frames are delimited by CE, and only frames with exactly
// FRAME_W bits are queued for the consumer.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | CE low (or CE high but its rising edge was not observed)
//   SHIFT  | CE high, shifting one bit per sample edge
//   COMMIT | one cycle after CE fell; length check and push decision
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int FRAME_W = 48,
  parameter int DEPTH   = 4,
  parameter int CPHA    = 0
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       CE,
  output logic [FRAME_W-1:0]         frame,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       len_err,
  output logic                       ovf,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int CW = cnt_width(FRAME_W);
  localparam logic [CW-1:0] CNT_GOOD = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic sck_meta, sck_s, sck_d;
  logic sdi_meta, sdi_s;
  logic ce_meta, ce_s, ce_d;

  logic sck_rise, sck_fall, sample;
  logic ce_rise;

  state_t state, state_n;
  logic   enter_shift;
  logic   shift_en;

  logic [FRAME_W-1:0] shreg;
  logic [CW-1:0]      bitcnt;

  logic               push_q;
  logic [FRAME_W-1:0] push_data;
  logic               len_bad;
  logic               drop;

  logic fifo_full;
  logic fifo_empty;

  // Two-flop synchronisers plus one history flop each on sck and CE. These
  // are deliberately left out of reset so that a CE already high when reset
  // releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    sck_meta <= sck;
    sck_s    <= sck_meta;
    sck_d    <= sck_s;
    sdi_meta <= sdi;
    sdi_s    <= sdi_meta;
    ce_meta  <= CE;
    ce_s     <= ce_meta;
    ce_d     <= ce_s;
  end

  assign sck_rise = sck_s && !sck_d;
  assign sck_fall = !sck_s && sck_d;
  assign sample   = (CPHA == 0) ? sck_rise : sck_fall;
  assign ce_rise  = ce_s && !ce_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    len_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (ce_rise) begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!ce_s) begin
          state_n = COMMIT;
        end else if (sample) begin
          shift_en = 1'b1;
        end
      end
      COMMIT: begin
        len_bad = (bitcnt != CNT_GOOD);
        state_n = ce_s ? SHIFT : IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign enter_shift = (state_n == SHIFT) && (state != SHIFT);

  // Shift register and saturating bit counter, cleared on every frame start.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (enter_shift) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_W-2:0], sdi_s};
      if (bitcnt != CNT_SAT) begin
        bitcnt <= bitcnt + CNT_ONE;
      end
    end
  end

  // Capture a good frame in COMMIT so the shifter is free to restart at once.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= (state == COMMIT) && (bitcnt == CNT_GOOD);
      if (state == COMMIT) begin
        push_data <= shreg;
      end
    end
  end

  // A full FIFO only drops the frame when the consumer is not popping in the
  // same cycle; a full FIFO is never empty, so frame_ready alone decides.
  assign drop = push_q && fifo_full && !frame_ready;

  // Sticky error flags; a new error takes priority over a clear.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      len_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (len_bad) begin
        len_err <= 1'b1;
      end else if (clr_err) begin
        len_err <= 1'b0;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
    end
  end

  spi_frame_fifo #(
    .W     (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push_q),
    .pop    (frame_ready),
    .din    (push_data),
    .dout   (frame),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign frame_valid = !fifo_empty;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a 48-bit CPHA=0 instance and an 8-bit
// CPHA=1 instance share clk, nreset, sck and sdi but have separate CE lines.
module tb_spi_frame_rx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        sck;
  logic        sdi;
  logic        ce0, ce1;
  logic        ready0, ready1;
  logic        clr0, clr1;

  logic [47:0] frame0;
  logic        valid0, len0, ovf0;
  logic [2:0]  level0;
  logic [7:0]  frame1;
  logic        valid1, len1, ovf1;
  logic [2:0]  level1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_frame_rx #(.FRAME_W(48), .DEPTH(4), .CPHA(0)) dut0 (
    .clk(clk), .nreset(nreset), .sck(sck), .sdi(sdi), .CE(ce0),
    .frame(frame0), .frame_valid(valid0), .frame_ready(ready0),
    .len_err(len0), .ovf(ovf0), .clr_err(clr0), .level(level0)
  );

  spi_frame_rx #(.FRAME_W(8), .DEPTH(4), .CPHA(1)) dut1 (
    .clk(clk), .nreset(nreset), .sck(sck), .sdi(sdi), .CE(ce1),
    .frame(frame1), .frame_valid(valid1), .frame_ready(ready1),
    .len_err(len1), .ovf(ovf1), .clr_err(clr1), .level(level1)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // CPHA=0: data changes while sck is low, sampled on the rising edge.
  task automatic bit_cpha0(input logic b);
    sck = 1'b0; sdi = b; tick(4);
    sck = 1'b1; tick(4);
  endtask

  // CPHA=1: data changes on the rising edge, sampled on the falling edge.
  task automatic bit_cpha1(input logic b);
    sck = 1'b1; sdi = b; tick(4);
    sck = 1'b0; tick(4);
  endtask

  // Sends the low n bits of d MSB first and drops CE at a negedge on return.
  task automatic send_frame(input logic [63:0] d, input int n, input bit which);
    if (which) ce1 = 1'b1; else ce0 = 1'b1;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      if (which) bit_cpha1(d[i]); else bit_cpha0(d[i]);
    end
    sck = 1'b0;
    tick(4);
    if (which) ce1 = 1'b0; else ce0 = 1'b0;
  endtask

  task automatic pop0();
    ready0 = 1'b1; tick(1); ready0 = 1'b0;
  endtask

  task automatic clear0();
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0; tick(3);
    checks++; if (frame0 !== 48'h0) begin errors++; $display("FAIL reset_frame: got %h expected 0", frame0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid0); end
    checks++; if (len0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got len=%b ovf=%b expected 0 0", len0, ovf0); end
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level0); end
    checks++; if (valid1 !== 1'b0 || level1 !== 3'd0) begin errors++; $display("FAIL reset_dut1: got valid=%b level=%0d expected 0 0", valid1, level1); end
    nreset = 1'b1; tick(2);
  endtask

  task automatic test_single();
    send_frame(64'h0000_A5A5_0123_4567, 48, 1'b0);
    tick(4);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0 at 4 clocks", valid0); end
    tick(1);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1 at 5 clocks", valid0); end
    checks++; if (frame0 !== 48'hA5A5_0123_4567) begin errors++; $display("FAIL single_frame: got %h expected a5a501234567", frame0); end
    checks++; if (len0 !== 1'b0 || level0 !== 3'd1) begin errors++; $display("FAIL single_status: got len=%b level=%0d expected 0 1", len0, level0); end
    pop0();
    checks++; if (valid0 !== 1'b0 || level0 !== 3'd0) begin errors++; $display("FAIL single_pop: got valid=%b level=%0d expected 0 0", valid0, level0); end
    tick(4);
  endtask

  task automatic test_length();
    send_frame(64'h0000_7FFF_FFFF_FFFF, 47, 1'b0);
    tick(8);
    checks++; if (len0 !== 1'b1 || level0 !== 3'd0) begin errors++; $display("FAIL short_frame: got len=%b level=%0d expected 1 0", len0, level0); end
    clear0();
    checks++; if (len0 !== 1'b0) begin errors++; $display("FAIL clr_err: got %b expected 0", len0); end
    tick(4);
    send_frame(64'h0001_FFFF_FFFF_FFFF, 49, 1'b0);
    tick(8);
    checks++; if (len0 !== 1'b1 || level0 !== 3'd0) begin errors++; $display("FAIL long_frame: got len=%b level=%0d expected 1 0", len0, level0); end
    clear0();
    tick(4);
    ce0 = 1'b1; tick(4); ce0 = 1'b0; tick(8);
    checks++; if (len0 !== 1'b1 || level0 !== 3'd0) begin errors++; $display("FAIL zero_bit_frame: got len=%b level=%0d expected 1 0", len0, level0); end
    clear0();
    tick(4);
    // clr_err asserted exactly in the COMMIT cycle of a failing frame.
    ce0 = 1'b1; tick(4); ce0 = 1'b0; tick(3);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
    checks++; if (len0 !== 1'b1) begin errors++; $display("FAIL err_beats_clr: got %b expected 1", len0); end
    clear0();
    tick(4);
    send_frame(64'h0000_1234_5678_9ABC, 48, 1'b0);
    tick(8);
    checks++; if (level0 !== 3'd1 || frame0 !== 48'h1234_5678_9ABC || len0 !== 1'b0) begin errors++; $display("FAIL good_after_err: got level=%0d frame=%h len=%b expected 1 123456789abc 0", level0, frame0, len0); end
    pop0();
    tick(4);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send_frame(64'(i), 48, 1'b0);
      tick(8);
    end
    checks++; if (level0 !== 3'd4 || ovf0 !== 1'b1) begin errors++; $display("FAIL overflow: got level=%0d ovf=%b expected 4 1", level0, ovf0); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (valid0 !== 1'b1 || frame0 !== 48'(i)) begin errors++; $display("FAIL overflow_pop%0d: got valid=%b frame=%h expected 1 %h", i, valid0, frame0, 48'(i)); end
      pop0();
    end
    checks++; if (valid0 !== 1'b0 || level0 !== 3'd0) begin errors++; $display("FAIL overflow_drained: got valid=%b level=%0d expected 0 0", valid0, level0); end
    clear0();
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf0); end
    tick(4);
  endtask

  task automatic test_full_push_pop();
    for (int i = 10; i <= 13; i++) begin
      send_frame(64'(i), 48, 1'b0);
      tick(8);
    end
    send_frame(64'd14, 48, 1'b0);
    tick(4);
    ready0 = 1'b1; tick(1); ready0 = 1'b0;
    checks++; if (level0 !== 3'd4 || ovf0 !== 1'b0) begin errors++; $display("FAIL full_push_pop: got level=%0d ovf=%b expected 4 0", level0, ovf0); end
    checks++; if (frame0 !== 48'd11) begin errors++; $display("FAIL full_push_pop_head: got %h expected 00000000000b", frame0); end
    tick(4);
    for (int i = 11; i <= 14; i++) begin
      checks++; if (frame0 !== 48'(i) || ovf0 !== 1'b0) begin errors++; $display("FAIL full_drain%0d: got frame=%h ovf=%b expected %h 0", i, frame0, ovf0, 48'(i)); end
      pop0();
    end
    tick(4);
  endtask

  task automatic test_cpha1();
    send_frame(64'h3C, 8, 1'b1);
    tick(8);
    checks++; if (valid1 !== 1'b1 || frame1 !== 8'h3C || len1 !== 1'b0) begin errors++; $display("FAIL cpha1_frame: got valid=%b frame=%h len=%b expected 1 3c 0", valid1, frame1, len1); end
    checks++; if (level0 !== 3'd0 || len0 !== 1'b0) begin errors++; $display("FAIL cpha1_isolation: got level0=%0d len0=%b expected 0 0", level0, len0); end
    ready1 = 1'b1; tick(1); ready1 = 1'b0;
    checks++; if (valid1 !== 1'b0 || level1 !== 3'd0) begin errors++; $display("FAIL cpha1_pop: got valid=%b level=%0d expected 0 0", valid1, level1); end
    tick(4);
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] d;
    d = 48'hFEDC_BA98_7654;
    send_frame(64'h00FF, 48, 1'b0);
    tick(8);
    ce0 = 1'b1; tick(4); ce0 = 1'b0; tick(8);
    checks++; if (level0 !== 3'd1 || len0 !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got level=%0d len=%b expected 1 1", level0, len0); end
    ce0 = 1'b1; tick(4);
    for (int i = 47; i >= 28; i--) bit_cpha0(d[i]);
    nreset = 1'b0; tick(1); nreset = 1'b1;
    checks++; if (valid0 !== 1'b0 || level0 !== 3'd0 || frame0 !== 48'h0 || len0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL mid_reset_values: got valid=%b level=%0d frame=%h len=%b ovf=%b expected all 0", valid0, level0, frame0, len0, ovf0); end
    for (int i = 27; i >= 0; i--) bit_cpha0(d[i]);
    sck = 1'b0; tick(4); ce0 = 1'b0; tick(8);
    checks++; if (level0 !== 3'd0 || len0 !== 1'b0) begin errors++; $display("FAIL mid_reset_tail: got level=%0d len=%b expected 0 0", level0, len0); end
    send_frame({16'h0, d}, 48, 1'b0);
    tick(8);
    checks++; if (level0 !== 3'd1 || frame0 !== 48'hFEDC_BA98_7654) begin errors++; $display("FAIL after_reset_frame: got level=%0d frame=%h expected 1 fedcba987654", level0, frame0); end
    pop0();
  endtask

  initial begin
    nreset = 1'b0;
    sck = 1'b0; sdi = 1'b0;
    ce0 = 1'b0; ce1 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    test_reset();
    test_single();
    test_length();
    test_overflow();
    test_full_push_pop();
    test_cpha1();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
